// File: rtl/alu_exec_pkg.sv
// Shared ALU definitions: ControlResult bit indices, op width, FSM states, datapath width.
// ST_MUL exists only when ALU_EXEC_MUL_EN is defined; used by alu_exec and the ALU control stage.
package alu_exec_pkg;

    localparam int ALU_XLEN = 32;
    localparam int OP_W     = 11;

    localparam int OP_ADD   = 0;
    localparam int OP_SUB   = 1;
    localparam int OP_SLL   = 2;
    localparam int OP_SLT   = 3;
    localparam int OP_SLTU  = 4;
    localparam int OP_XOR   = 5;
    localparam int OP_SRL   = 6;
    localparam int OP_SRA   = 7;
    localparam int OP_OR    = 8;
    localparam int OP_AND   = 9;
    localparam int OP_PASSB = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
`ifdef ALU_EXEC_MUL_EN
        MUL   = 2'd2,
`endif
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } sh_kind_e;

    function automatic logic is_onehot(input logic [OP_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Single-cycle result; shift ops only reach here with a zero shift amount.
    function automatic logic [ALU_XLEN-1:0] alu_single(input logic [OP_W-1:0]     op,
                                                       input logic [ALU_XLEN-1:0] a,
                                                       input logic [ALU_XLEN-1:0] b);
        logic [ALU_XLEN-1:0] r;
        r = '0;
        case (1'b1)
            op[OP_ADD]:   r = a + b;
            op[OP_SUB]:   r = a - b;
            op[OP_SLT]:   r = {{(ALU_XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            op[OP_SLTU]:  r = {{(ALU_XLEN-1){1'b0}}, (a < b)};
            op[OP_XOR]:   r = a ^ b;
            op[OP_OR]:    r = a | b;
            op[OP_AND]:   r = a & b;
            op[OP_PASSB]: r = b;
            op[OP_SLL],
            op[OP_SRL],
            op[OP_SRA]:   r = a;
            default:      r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_exec_shifter.sv
// Iterative one-bit-per-cycle shifter with down-counter; load captures operand and amount.
// last is high during the final step; shifted is the value after the current step.
module alu_exec_shifter
    import alu_exec_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [1:0]      kind,
    input  logic [4:0]      shamt,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] shifted,
    output logic            last
);

    logic [XLEN-1:0] data;
    logic [4:0]      cnt;
    logic [1:0]      kind_q;

    always_comb begin
        case (kind_q)
            SH_SLL:  shifted = {data[XLEN-2:0], 1'b0};
            SH_SRL:  shifted = {1'b0, data[XLEN-1:1]};
            default: shifted = {data[XLEN-1], data[XLEN-1:1]};
        endcase
    end

    assign last = (cnt == 5'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            data   <= '0;
            cnt    <= '0;
            kind_q <= SH_SLL;
        end else if (load) begin
            data   <= din;
            cnt    <= shamt;
            kind_q <= kind;
        end else if (step && cnt != 5'd0) begin
            data <= shifted;
            cnt  <= cnt - 5'd1;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: single-cycle ops in 1 cycle, shifts in 1+shamt, optional multiply (ALU_EXEC_MUL_EN) in 33.
// Valid/ready both sides; result held in DONE until OutReady, new op accepted in the same cycle it drains.
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [OP_W-1:0]  ControlResult,
    input  logic             IsMul,
    input  logic [XLEN-1:0]  OpA,
    input  logic [XLEN-1:0]  OpB,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [XLEN-1:0]  Result,
    output logic             Zero,
    output logic             Illegal
);

    state_e          state;
    logic            accept;
    logic            legal;
    logic            is_shift;
    logic            sh_load;
    logic [1:0]      sh_kind;
    logic [XLEN-1:0] single_res;
    logic [XLEN-1:0] sh_shifted;
    logic            sh_last;

    assign InReady = !rst && ((state == IDLE) || (state == DONE && OutReady));
    assign accept  = InValid && InReady;

    // IsMul overrides ControlResult; without the multiplier it decodes as illegal.
    assign legal      = !IsMul && is_onehot(ControlResult);
    assign is_shift   = ControlResult[OP_SLL] | ControlResult[OP_SRL] | ControlResult[OP_SRA];
    assign sh_load    = accept && legal && is_shift && (OpB[4:0] != 5'd0);
    assign sh_kind    = ControlResult[OP_SLL] ? SH_SLL : (ControlResult[OP_SRL] ? SH_SRL : SH_SRA);
    assign single_res = legal ? alu_single(ControlResult, OpA, OpB) : '0;

    alu_exec_shifter #(.XLEN(XLEN)) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (sh_load),
        .step    (state == SHIFT),
        .kind    (sh_kind),
        .shamt   (OpB[4:0]),
        .din     (OpA),
        .shifted (sh_shifted),
        .last    (sh_last)
    );

`ifdef ALU_EXEC_MUL_EN
    logic [XLEN-1:0] mul_acc;
    logic [XLEN-1:0] mul_mcand;
    logic [XLEN-1:0] mul_mplier;
    logic [4:0]      mul_cnt;
    logic [XLEN-1:0] mul_sum;

    assign mul_sum = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            OutValid <= 1'b0;
            Result   <= '0;
            Zero     <= 1'b0;
            Illegal  <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
`ifdef ALU_EXEC_MUL_EN
                        if (IsMul) begin
                            state      <= MUL;
                            OutValid   <= 1'b0;
                            mul_acc    <= '0;
                            mul_mcand  <= OpA;
                            mul_mplier <= OpB;
                            mul_cnt    <= 5'd31;
                        end else
`endif
                        if (sh_load) begin
                            state    <= SHIFT;
                            OutValid <= 1'b0;
                        end else begin
                            state    <= DONE;
                            OutValid <= 1'b1;
                            Result   <= single_res;
                            Zero     <= (single_res == '0);
                            Illegal  <= !legal;
                        end
                    end else if (state == DONE && OutReady) begin
                        state    <= IDLE;
                        OutValid <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (sh_last) begin
                        state    <= DONE;
                        OutValid <= 1'b1;
                        Result   <= sh_shifted;
                        Zero     <= (sh_shifted == '0);
                        Illegal  <= 1'b0;
                    end
                end
`ifdef ALU_EXEC_MUL_EN
                // Unsigned shift-add, one multiplier bit per cycle, low word kept.
                MUL: begin
                    mul_acc    <= mul_sum;
                    mul_mcand  <= {mul_mcand[XLEN-2:0], 1'b0};
                    mul_mplier <= {1'b0, mul_mplier[XLEN-1:1]};
                    if (mul_cnt == 5'd0) begin
                        state    <= DONE;
                        OutValid <= 1'b1;
                        Result   <= mul_sum;
                        Zero     <= (mul_sum == '0);
                        Illegal  <= 1'b0;
                    end else begin
                        mul_cnt <= mul_cnt - 5'd1;
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    OutValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed vector bench for alu_exec: op table plus backpressure, back-to-back and reset sequences.
module tb_alu_exec;

    logic        clk;
    logic        rst;
    logic        InValid;
    logic        InReady;
    logic [10:0] ControlResult;
    logic        IsMul;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Result;
    logic        Zero;
    logic        Illegal;

    int errors = 0;
    int checks = 0;

    alu_exec #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .InValid       (InValid),
        .InReady       (InReady),
        .ControlResult (ControlResult),
        .IsMul         (IsMul),
        .OpA           (OpA),
        .OpB           (OpB),
        .OutValid      (OutValid),
        .OutReady      (OutReady),
        .Result        (Result),
        .Zero          (Zero),
        .Illegal       (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [10:0] ctrl;
        logic        mul;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where OutValid is first seen.
    task automatic run_op(input logic [10:0] c, input logic m, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output bit timeout);
        int n;
        n = 0;
        while (!InReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        InValid       = 1'b1;
        ControlResult = c;
        IsMul         = m;
        OpA           = a;
        OpB           = b;
        @(posedge clk);
        #1 InValid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!OutValid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        timeout = !OutValid;
    endtask

    initial begin
        int  lat;
        bit  to;
        bit  seen;

        vecs[0]  = '{"add_wrap",  11'h001, 1'b0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b0, 1};
        vecs[1]  = '{"sub_zero",  11'h002, 1'b0, 32'h5,        32'h5,        32'h0,        1'b1, 1'b0, 1};
        vecs[2]  = '{"slt",       11'h008, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 1};
        vecs[3]  = '{"sltu",      11'h010, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 1};
        vecs[4]  = '{"sra31",     11'h080, 1'b0, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0, 32};
        vecs[5]  = '{"sll0",      11'h004, 1'b0, 32'h12345678, 32'h0,        32'h12345678, 1'b0, 1'b0, 1};
        vecs[6]  = '{"sll4",      11'h004, 1'b0, 32'h1,        32'h4,        32'h10,       1'b0, 1'b0, 5};
        vecs[7]  = '{"srl3",      11'h040, 1'b0, 32'h80000000, 32'hFFFFFFE3, 32'h10000000, 1'b0, 1'b0, 4};
        vecs[8]  = '{"xor",       11'h020, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1};
        vecs[9]  = '{"or",        11'h100, 1'b0, 32'h0F000000, 32'h000000F0, 32'h0F0000F0, 1'b0, 1'b0, 1};
        vecs[10] = '{"and",       11'h200, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1};
        vecs[11] = '{"passb",     11'h400, 1'b0, 32'h1,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1};
        vecs[12] = '{"ill_multi", 11'h003, 1'b0, 32'h7,        32'h9,        32'h0,        1'b1, 1'b1, 1};
        vecs[13] = '{"ill_none",  11'h000, 1'b0, 32'h7,        32'h9,        32'h0,        1'b1, 1'b1, 1};
`ifdef ALU_EXEC_MUL_EN
        vecs[14] = '{"mul",       11'h001, 1'b1, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 1'b0, 1'b0, 33};
`else
        vecs[14] = '{"mul_off",   11'h001, 1'b1, 32'hFFFFFFFF, 32'h2,        32'h0,        1'b1, 1'b1, 1};
`endif
        vecs[15] = '{"sub_wrap",  11'h002, 1'b0, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1'b0, 1};

        rst = 1'b1; InValid = 1'b0; ControlResult = '0; IsMul = 1'b0;
        OpA = '0; OpB = '0; OutReady = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_inready",  {31'b0, InReady},  32'h0);
        chk("rst_outvalid", {31'b0, OutValid}, 32'h0);
        chk("rst_result",   Result,            32'h0);
        chk("rst_zero",     {31'b0, Zero},     32'h0);
        chk("rst_illegal",  {31'b0, Illegal},  32'h0);
        rst = 1'b0;
        #1 chk("rst_release_inready", {31'b0, InReady}, 32'h1);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].ctrl, vecs[i].mul, vecs[i].a, vecs[i].b, lat, to);
            chk({vecs[i].name, "_timeout"}, {31'b0, to}, 32'h0);
            chk({vecs[i].name, "_lat"},     lat,          vecs[i].lat);
            chk({vecs[i].name, "_res"},     Result,       vecs[i].res);
            chk({vecs[i].name, "_zero"},    {31'b0, Zero},    {31'b0, vecs[i].zero});
            chk({vecs[i].name, "_illegal"}, {31'b0, Illegal}, {31'b0, vecs[i].ill});
        end
        @(negedge clk);
        chk("drain_outvalid", {31'b0, OutValid}, 32'h0);

        // Backpressure: result held while OutReady is low.
        OutReady = 1'b0;
        run_op(11'h001, 1'b0, 32'd3, 32'd4, lat, to);
        chk("hold_timeout", {31'b0, to}, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_result",   Result,            32'd7);
            chk("hold_outvalid", {31'b0, OutValid}, 32'h1);
            chk("hold_inready",  {31'b0, InReady},  32'h0);
        end

        // Release and stream 10 back-to-back ADDs, one result per cycle.
        OutReady = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                @(negedge clk);
                chk("b2b_outvalid", {31'b0, OutValid}, 32'h1);
                chk("b2b_result",   Result,            2 * (k - 1) + 100);
            end
            InValid = 1'b1; ControlResult = 11'h001; IsMul = 1'b0;
            OpA = k; OpB = k + 100;
            #1 chk("b2b_inready", {31'b0, InReady}, 32'h1);
        end
        @(negedge clk);
        chk("b2b_last_outvalid", {31'b0, OutValid}, 32'h1);
        chk("b2b_last_result",   Result,            32'd118);
        InValid = 1'b0;
        @(negedge clk);
        chk("b2b_idle", {31'b0, OutValid}, 32'h0);

        // Reset in the middle of a long shift discards the operation.
        InValid = 1'b1; ControlResult = 11'h004; OpA = 32'h1; OpB = 32'd20;
        @(posedge clk);
        #1 InValid = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (OutValid) seen = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_inready", {31'b0, InReady}, 32'h0);
        rst = 1'b0;
        #1 chk("midrst_release_inready", {31'b0, InReady}, 32'h1);
        chk("midrst_result", Result, 32'h0);
        repeat (40) begin
            @(negedge clk);
            if (OutValid) seen = 1'b1;
        end
        chk("midrst_no_outvalid", {31'b0, seen}, 32'h0);
        chk("midrst_idle_inready", {31'b0, InReady}, 32'h1);

        // After reset the block still works.
        run_op(11'h001, 1'b0, 32'd40, 32'd2, lat, to);
        chk("post_rst_res", Result, 32'd42);
        chk("post_rst_lat", lat,    32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock; the block's single clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 InValid  input  1  upstream holds a valid operation.
REQ-005 InReady  output  1  block accepts the operation this cycle.
REQ-006 ControlResult  input  11  one-hot ALU op from the ALU control stage.
REQ-007 IsMul  input  1  selects multiply; it overrides ControlResult.
REQ-008 OpA  input  XLEN  operand A.
REQ-009 OpB  input  XLEN  operand B; shift amount is OpB[4:0].
REQ-010 OutValid  output  1  Result is valid.
REQ-011 OutReady  input  1  downstream consumes the result.
REQ-012 Result  output  XLEN  registered result.
REQ-013 Zero  output  1  registered flag: Result == 0.
REQ-014 Illegal  output  1  registered flag: the op code was invalid.

Function
REQ-015 ControlResult bit map SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
REQ-016 A transfer in SHALL occur when InValid && InReady; operands and op are captured into internal registers.
REQ-017 FSM states SHALL be IDLE, SHIFT, MUL and DONE.
REQ-018 InReady SHALL be high in IDLE, and high in DONE when OutReady is high; it SHALL be low otherwise.
REQ-019 On accept in cycle N, single-cycle ops SHALL go to DONE, with OutValid high at N+1.
REQ-020 Shifts SHALL iterate one bit per cycle in SHIFT for shamt cycles: OutValid at N+1+shamt; shamt=0 gives N+1 with Result=OpA.
REQ-021 SRA SHALL replicate OpA[31]; SLT/SLTU SHALL return 0 or 1 zero-extended.
REQ-022 ADD/SUB SHALL wrap modulo 2^32, with no overflow flag.
REQ-023 A zero or multi-hot ControlResult (with IsMul low) SHALL complete in one cycle with Result=0, Illegal=1, Zero=1.
REQ-024 In DONE, Result, Zero and Illegal SHALL be held stable while OutReady is low.
REQ-025 DONE with OutReady high and no new accept SHALL go to IDLE, with OutValid low next cycle.
REQ-026 DONE with OutReady high and InValid high SHALL accept a new op in the same cycle (back-to-back, one op per cycle for single-cycle ops).
REQ-027 InValid SHALL be ignored in SHIFT and MUL.

Reset
REQ-028 rst SHALL force IDLE, OutValid=0, Result=0, Zero=0, Illegal=0, and clear the internal counters, including when rst arrives in SHIFT, MUL or DONE.
REQ-029 An operation in flight at reset SHALL be discarded, with no OutValid pulse.
REQ-030 InReady SHALL be 0 while rst is high, and 1 in the first cycle after rst deasserts.

Configuration
REQ-031 With ALU_EXEC_MUL_EN defined, IsMul=1 SHALL run an unsigned shift-add multiply for 32 cycles in MUL; Result is the low 32 bits of OpA*OpB, with OutValid at N+33.
REQ-032 Without ALU_EXEC_MUL_EN, the MUL state and multiplier SHALL be absent, and IsMul=1 SHALL complete as illegal per REQ-023.

Structure
REQ-033 A shared package SHALL hold the ControlResult bit-index constants, the op width (11), the FSM state typedef and XLEN; the ALU control block uses the same package.
REQ-034 One sub-module, alu_exec_shifter (iterative shift datapath with counter), is natural; everything else SHALL be in alu_exec.

Verification
REQ-035 ADD: OpA=0x7FFFFFFF, OpB=1 -> Result=0x80000000, OutValid one cycle after accept.
REQ-036 SUB: OpA=5, OpB=5 -> Result=0, Zero=1; SLT: OpA=0xFFFFFFFF, OpB=1 -> 1; SLTU with the same operands -> 0.
REQ-037 SRA: OpA=0x80000000, OpB=31 -> Result=0xFFFFFFFF, OutValid 32 cycles after accept; SLL with OpB=0 -> Result=OpA after 1 cycle.
REQ-038 OutReady held low 5 cycles -> Result stable, InReady low; then OutReady=1 with InValid=1 -> next op accepted that cycle, and 10 back-to-back ADDs complete in 10 cycles.
REQ-039 ControlResult=0x003 -> Illegal=1, Result=0; rst pulsed mid-SHIFT -> OutValid never asserts, and IDLE with InReady=1 the cycle after rst drops.
REQ-040 ALU_EXEC_MUL_EN defined: OpA=0xFFFFFFFF, OpB=2 -> Result=0xFFFFFFFE at N+33; macro undefined: IsMul=1 -> Illegal=1 at N+1.
